wb2axip_pkt_sfifo: RTL and testbench

Synchronous, parametrised packet FIFO: the successor to the plain synchronous data FIFO.
- Write side stores words speculatively. A packet becomes visible to the reader only when its last word (i_last) is accepted.
- A partial packet can be discarded by an explicit abort, or automatically when it can never fit.
- Sits between bus-side stream producers (AXI-stream or Wishbone bridges) and consumers that must never see a truncated packet.

---
 rtl/wb2axip_pkt_sfifo_pkg.sv | 17 +
 rtl/wb2axip_pkt_sfifo_mem.sv | 24 ++
 rtl/wb2axip_pkt_sfifo.sv | 138 +++++++++++++
 tb/tb_wb2axip_pkt_sfifo.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb2axip_pkt_sfifo_pkg.sv
// Shared types for the packet FIFO: control-state encoding and pointer sizing.
package wb2axip_pkt_sfifo_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PKT  = 2'b01,
    ST_DROP = 2'b10
  } state_e;

  localparam int unsigned DEF_LGFLEN = 4;

  // Pointers carry one extra bit so full and empty are distinguishable.
  function automatic int unsigned ptr_width(input int unsigned lgflen);
    return lgflen + 1;
  endfunction

endpackage

// File: rtl/wb2axip_pkt_sfifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous (fall-through) read.
module wb2axip_pkt_sfifo_mem #(
  parameter int unsigned BW     = 8,
  parameter int unsigned LGFLEN = 4
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [LGFLEN-1:0] i_waddr,
  input  logic [BW:0]       i_wdata,
  input  logic [LGFLEN-1:0] i_raddr,
  output logic [BW:0]       o_rdata
);

  localparam int unsigned FLEN = 1 << LGFLEN;

  logic [BW:0] mem [FLEN];

  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = mem[i_raddr];

endmodule

// File: rtl/wb2axip_pkt_sfifo.sv
// Packet FIFO: words are written speculatively and become readable only once the
// packet's last word commits; partial packets can be aborted or auto-dropped.
module wb2axip_pkt_sfifo
  import wb2axip_pkt_sfifo_pkg::*;
#(
  parameter int unsigned BW            = 8,
  parameter int unsigned LGFLEN        = DEF_LGFLEN,
  parameter int unsigned LGAF          = LGFLEN,
  parameter int unsigned AF_LEVEL      = 12,
  parameter bit          OPT_AUTO_DROP = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wr,
  input  logic [BW-1:0]   i_data,
  input  logic            i_last,
  input  logic            i_abort,
  output logic            o_full,
  output logic            o_afull,
  output logic            o_drop,
  input  logic            i_rd,
  output logic [BW-1:0]   o_data,
  output logic            o_last,
  output logic            o_empty,
  output logic [LGFLEN:0] o_fill,
  output logic [LGFLEN:0] o_pkts
);

  localparam int unsigned PW   = ptr_width(LGFLEN);
  localparam int unsigned FLEN = 1 << LGFLEN;
  localparam logic [PW-1:0]   FLEN_P    = PW'(FLEN);
  localparam logic [LGAF:0]   AF_THRESH = (LGAF + 1)'(AF_LEVEL);
  localparam logic [PW-1:0]   AF_P      = PW'(AF_THRESH);

  state_e        state, state_n;
  logic [PW-1:0] wr_addr, wr_commit, rd_addr;
  logic [PW-1:0] wr_addr_n, wr_commit_n, rd_addr_n;
  logic [PW-1:0] occ_n;
  logic          w_wr, w_rd, abort_pkt, overflow;
  logic          pkt_inc, pkt_dec;
  logic [BW:0]   head;

  wb2axip_pkt_sfifo_mem #(
    .BW     (BW),
    .LGFLEN (LGFLEN)
  ) u_mem (
    .i_clk   (i_clk),
    .i_we    (w_wr),
    .i_waddr (wr_addr[LGFLEN-1:0]),
    .i_wdata ({i_last, i_data}),
    .i_raddr (rd_addr[LGFLEN-1:0]),
    .o_rdata (head)
  );

  assign o_last = head[BW];
  assign o_data = head[BW-1:0];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_n;
  end

  // Next-state decode plus the write/read acceptance it implies.
  always_comb begin
    state_n   = state;
    w_wr      = 1'b0;
    abort_pkt = 1'b0;
    overflow  = 1'b0;
    w_rd      = i_rd && !o_empty;
    case (state)
      ST_IDLE: begin
        if (i_wr && !o_full && !i_abort) begin
          w_wr = 1'b1;
          if (!i_last) state_n = ST_PKT;
        end
      end
      ST_PKT: begin
        if (i_abort) begin
          abort_pkt = 1'b1;
          state_n   = ST_IDLE;
        end else if (OPT_AUTO_DROP && i_wr && o_full && (wr_commit == rd_addr)) begin
          overflow = 1'b1;
          state_n  = ST_DROP;
        end else if (i_wr && !o_full) begin
          w_wr = 1'b1;
          if (i_last) state_n = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (i_wr && i_last) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Pointer updates; a discard rewinds the speculative pointer to the commit point.
  always_comb begin
    wr_addr_n   = wr_addr;
    wr_commit_n = wr_commit;
    rd_addr_n   = rd_addr;
    if (abort_pkt || overflow) wr_addr_n = wr_commit;
    else if (w_wr)             wr_addr_n = wr_addr + PW'(1);
    if (w_wr && i_last)        wr_commit_n = wr_addr + PW'(1);
    if (w_rd)                  rd_addr_n = rd_addr + PW'(1);
    occ_n   = wr_addr_n - rd_addr_n;
    pkt_inc = w_wr && i_last;
    pkt_dec = w_rd && head[BW];
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_addr   <= '0;
      wr_commit <= '0;
      rd_addr   <= '0;
      o_empty   <= 1'b1;
      o_full    <= 1'b0;
      o_afull   <= 1'b0;
      o_drop    <= 1'b0;
      o_fill    <= '0;
      o_pkts    <= '0;
    end else begin
      wr_addr   <= wr_addr_n;
      wr_commit <= wr_commit_n;
      rd_addr   <= rd_addr_n;
      o_empty   <= (wr_commit_n == rd_addr_n);
      o_full    <= (occ_n == FLEN_P);
      o_afull   <= (occ_n >= AF_P);
      o_drop    <= abort_pkt || overflow;
      o_fill    <= wr_commit_n - rd_addr_n;
      case ({pkt_inc, pkt_dec})
        2'b10:   o_pkts <= o_pkts + PW'(1);
        2'b01:   o_pkts <= o_pkts - PW'(1);
        default: o_pkts <= o_pkts;
      endcase
    end
  end

endmodule

// File: tb/tb_wb2axip_pkt_sfifo.sv
// Bench for wb2axip_pkt_sfifo: directed scenarios plus random traffic against a
// queue-based packet model (committed queue + speculative queue).
module tb_wb2axip_pkt_sfifo;

  localparam int unsigned BW       = 8;
  localparam int unsigned LGFLEN   = 4;
  localparam int unsigned FLEN     = 16;
  localparam int unsigned AF_LEVEL = 12;

  logic              i_clk;
  logic              i_reset;
  logic              i_wr;
  logic [BW-1:0]     i_data;
  logic              i_last;
  logic              i_abort;
  logic              i_rd;
  logic              o_full;
  logic              o_afull;
  logic              o_drop;
  logic [BW-1:0]     o_data;
  logic              o_last;
  logic              o_empty;
  logic [LGFLEN:0]   o_fill;
  logic [LGFLEN:0]   o_pkts;

  wb2axip_pkt_sfifo #(
    .BW            (BW),
    .LGFLEN        (LGFLEN),
    .LGAF          (LGFLEN),
    .AF_LEVEL      (AF_LEVEL),
    .OPT_AUTO_DROP (1'b1)
  ) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_wr    (i_wr),
    .i_data  (i_data),
    .i_last  (i_last),
    .i_abort (i_abort),
    .o_full  (o_full),
    .o_afull (o_afull),
    .o_drop  (o_drop),
    .i_rd    (i_rd),
    .o_data  (o_data),
    .o_last  (o_last),
    .o_empty (o_empty),
    .o_fill  (o_fill),
    .o_pkts  (o_pkts)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int tests;
  int fails;

  // Model: entries are {last, data}.
  logic [BW:0] cq[$];
  logic [BW:0] sq[$];
  bit          in_pkt;
  bit          dropping;
  bit          exp_drop;
  int          exp_pkts;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    cq.delete();
    sq.delete();
    in_pkt   = 1'b0;
    dropping = 1'b0;
    exp_drop = 1'b0;
    exp_pkts = 0;
  endtask

  task automatic model_step(input logic wr, input logic [BW-1:0] d, input logic last,
                            input logic ab, input logic rd);
    int          tot;
    bit          full;
    bit          was_empty;
    logic [BW:0] h;
    tot       = cq.size() + sq.size();
    full      = (tot == FLEN);
    was_empty = (cq.size() == 0);
    exp_drop  = 1'b0;
    if (rd && !was_empty) begin
      h = cq.pop_front();
      if (h[BW]) exp_pkts--;
    end
    if (ab && in_pkt) begin
      sq.delete();
      in_pkt   = 1'b0;
      exp_drop = 1'b1;
    end else if (dropping) begin
      if (wr && last) dropping = 1'b0;
    end else if (in_pkt && wr && full && was_empty) begin
      sq.delete();
      in_pkt   = 1'b0;
      dropping = 1'b1;
      exp_drop = 1'b1;
    end else if (wr && !full && !ab) begin
      sq.push_back({last, d});
      if (last) begin
        foreach (sq[i]) cq.push_back(sq[i]);
        sq.delete();
        exp_pkts++;
        in_pkt = 1'b0;
      end else begin
        in_pkt = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    int tot;
    tot = cq.size() + sq.size();
    check("empty", 32'(o_empty), 32'(cq.size() == 0));
    check("full",  32'(o_full),  32'(tot == FLEN));
    check("afull", 32'(o_afull), 32'(tot >= AF_LEVEL));
    check("drop",  32'(o_drop),  32'(exp_drop));
    check("fill",  32'(o_fill),  32'(cq.size()));
    check("pkts",  32'(o_pkts),  32'(exp_pkts));
    if (cq.size() > 0) check("head", 32'({o_last, o_data}), 32'(cq[0]));
  endtask

  // Called at a falling edge: drive, clock, update model, compare on the next falling edge.
  task automatic step(input logic wr, input logic [BW-1:0] d, input logic last,
                      input logic ab, input logic rd);
    i_wr    = wr;
    i_data  = d;
    i_last  = last;
    i_abort = ab;
    i_rd    = rd;
    @(posedge i_clk);
    model_step(wr, d, last, ab, rd);
    @(negedge i_clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    i_wr    = 1'b0;
    i_data  = '0;
    i_last  = 1'b0;
    i_abort = 1'b0;
    i_rd    = 1'b0;
  endtask

  task automatic async_reset(input string tag);
    idle_inputs();
    #2 i_reset = 1'b1;
    #1;
    check({tag, "_empty"}, 32'(o_empty), 32'd1);
    check({tag, "_fill"},  32'(o_fill),  32'd0);
    check({tag, "_pkts"},  32'(o_pkts),  32'd0);
    check({tag, "_full"},  32'(o_full),  32'd0);
    check({tag, "_afull"}, 32'(o_afull), 32'd0);
    check({tag, "_drop"},  32'(o_drop),  32'd0);
    model_reset();
    @(negedge i_clk);
    i_reset = 1'b0;
    compare_all();
  endtask

  task automatic rand_phase(input int n, input int p_wr, input int p_last,
                            input int p_ab, input int p_rd);
    for (int k = 0; k < n; k++) begin
      step(1'($urandom_range(0, 99) < p_wr), 8'($urandom_range(0, 255)),
           1'($urandom_range(0, 99) < p_last), 1'($urandom_range(0, 99) < p_ab),
           1'($urandom_range(0, 99) < p_rd));
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    idle_inputs();
    model_reset();
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    check("rst_empty", 32'(o_empty), 32'd1);
    check("rst_fill",  32'(o_fill),  32'd0);
    check("rst_pkts",  32'(o_pkts),  32'd0);
    check("rst_full",  32'(o_full),  32'd0);
    check("rst_drop",  32'(o_drop),  32'd0);
    i_reset = 1'b0;
    compare_all();

    // Three-word packet becomes visible only on its last word.
    step(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    check("a1_empty", 32'(o_empty), 32'd1);
    step(1'b1, 8'hA2, 1'b0, 1'b0, 1'b0);
    check("a2_empty", 32'(o_empty), 32'd1);
    step(1'b1, 8'hA3, 1'b1, 1'b0, 1'b0);
    check("a3_empty", 32'(o_empty), 32'd0);
    check("a3_fill",  32'(o_fill),  32'd3);
    check("a3_pkts",  32'(o_pkts),  32'd1);
    check("a_rd0", 32'({o_last, o_data}), 32'h0A1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("a_rd1", 32'({o_last, o_data}), 32'h0A2);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("a_rd2", 32'({o_last, o_data}), 32'h1A3);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("a_done_empty", 32'(o_empty), 32'd1);

    // Explicit abort of a partial packet, then a single-word packet.
    step(1'b1, 8'h51, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h52, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h53, 1'b1, 1'b1, 1'b0);
    check("ab_drop",  32'(o_drop),  32'd1);
    check("ab_fill",  32'(o_fill),  32'd0);
    check("ab_empty", 32'(o_empty), 32'd1);
    check("ab_full",  32'(o_full),  32'd0);
    step(1'b1, 8'hB1, 1'b1, 1'b0, 1'b0);
    check("ab_drop_gone", 32'(o_drop), 32'd0);
    check("b_head", 32'({o_last, o_data}), 32'h1B1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Overflow with nothing committed triggers auto-drop.
    for (int k = 0; k < 16; k++) step(1'b1, 8'(8'h10 + k), 1'b0, 1'b0, 1'b0);
    check("ov_full", 32'(o_full), 32'd1);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0);
    check("ov_drop", 32'(o_drop), 32'd1);
    check("ov_full_clr", 32'(o_full), 32'd0);
    step(1'b1, 8'h9A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h9B, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h9C, 1'b1, 1'b0, 1'b0);
    check("ov_fill", 32'(o_fill), 32'd0);
    check("ov_empty", 32'(o_empty), 32'd1);

    // Full with committed data present: no drop, read frees a slot.
    for (int k = 0; k < 4; k++) step(1'b1, 8'(8'h40 + k), 1'(k == 3), 1'b0, 1'b0);
    for (int k = 0; k < 12; k++) step(1'b1, 8'(8'h60 + k), 1'b0, 1'b0, 1'b0);
    check("cf_full", 32'(o_full), 32'd1);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    check("cf_nodrop", 32'(o_drop), 32'd0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("cf_full_clr", 32'(o_full), 32'd0);
    check("cf_afull", 32'(o_afull), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    check("cf_abort_drop", 32'(o_drop), 32'd1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Commit and read of a last word in the same cycle.
    step(1'b1, 8'hC1, 1'b1, 1'b0, 1'b0);
    check("sc_pre_pkts", 32'(o_pkts), 32'd1);
    step(1'b1, 8'hC2, 1'b1, 1'b0, 1'b1);
    check("sc_pkts", 32'(o_pkts), 32'd1);
    check("sc_fill", 32'(o_fill), 32'd1);
    check("sc_head", 32'({o_last, o_data}), 32'h1C2);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-packet with five committed words.
    for (int k = 0; k < 5; k++) step(1'b1, 8'(8'hD0 + k), 1'(k == 4), 1'b0, 1'b0);
    step(1'b1, 8'hDE, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hDF, 1'b0, 1'b0, 1'b0);
    check("mr_fill", 32'(o_fill), 32'd5);
    async_reset("mr");

    // Forty words in 4-word packets with concurrent reads: pointers wrap.
    for (int k = 0; k < 40; k++) step(1'b1, 8'(8'h80 + k), 1'(k % 4 == 3), 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check("wrap_empty", 32'(o_empty), 32'd1);

    // Random traffic across balanced, write-heavy and read-heavy mixes.
    rand_phase(800, 60, 25, 4, 50);
    rand_phase(600, 85, 5, 2, 15);
    async_reset("rr");
    rand_phase(600, 70, 10, 6, 30);
    rand_phase(600, 40, 40, 3, 80);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
